timer_run_ctrl: RTL and testbench

- Parametrised, multi-channel successor to the timer's single-channel active handler.
- Each channel turns an active-low start/stop button into a debounced, release-triggered toggle that drives a four-state run machine: IDLE, RUN, PAUSE, DONE.
- Sits between the board buttons / mode logic and the per-channel count engines; active[i] gates counting on channel i.

---
 rtl/timer_run_ctrl.sv | 126 ++++++++++++
 tb/tb_timer_run_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : timer_run_ctrl
//  Purpose  : Multi-channel run controller. Each channel debounces an
//             active-low start/stop button into a release-triggered toggle
//             that drives an IDLE/RUN/PAUSE/DONE run machine.
//  Revision : 1.0  initial release
// ============================================================================
module timer_run_ctrl #(
   parameter int NUM_CH          = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int AUTO_RESTART    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] resetter,
   input  logic [NUM_CH-1:0] start_stop_n,
   input  logic [NUM_CH-1:0] stop_condition,
   output logic [NUM_CH-1:0] active,
   output logic [NUM_CH-1:0] paused,
   output logic [NUM_CH-1:0] done,
   output logic [NUM_CH-1:0] done_pulse
);

   localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_deb_max = c_cnt_w'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic               r_s1;
      logic               r_s2;
      logic [c_cnt_w-1:0] r_cnt;
      logic               w_armed;
      logic               w_toggle;
      state_t             r_state;
      state_t             w_next;
      logic               r_active;
      logic               r_paused;
      logic               r_done;
      logic               r_done_pulse;

      // Two-flop synchroniser; resets to the released level so no press is seen
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
         end else begin
            r_s1 <= start_stop_n[gi];
            r_s2 <= r_s1;
         end
      end

      // Count consecutive low samples, saturating; a clear discards a press in progress
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt <= '0;
         end else if (resetter[gi] || r_s2) begin
            r_cnt <= '0;
         end else if (r_cnt != c_deb_max) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
      end

      // Toggle fires for one cycle when an armed press is released
      assign w_armed  = (r_cnt == c_deb_max);
      assign w_toggle = r_s2 & w_armed;

      // Next-state: clear, then terminal count, then toggle, then auto restart
      always_comb begin
         w_next = r_state;
         if (resetter[gi]) begin
            w_next = ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_toggle && !stop_condition[gi]) w_next = ST_RUN;
               end
               ST_RUN: begin
                  if (stop_condition[gi])  w_next = ST_DONE;
                  else if (w_toggle)       w_next = ST_PAUSE;
               end
               ST_PAUSE: begin
                  if (w_toggle && !stop_condition[gi]) w_next = ST_RUN;
               end
               ST_DONE: begin
                  if (w_toggle)
                     w_next = ST_IDLE;
                  else if ((AUTO_RESTART != 0) && !stop_condition[gi])
                     w_next = ST_RUN;
               end
               default: w_next = ST_IDLE;
            endcase
         end
      end

      // State register with outputs decoded from the next state so they align with it
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_state      <= ST_IDLE;
            r_active     <= 1'b0;
            r_paused     <= 1'b0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
         end else begin
            r_state      <= w_next;
            r_active     <= (w_next == ST_RUN);
            r_paused     <= (w_next == ST_PAUSE);
            r_done       <= (w_next == ST_DONE);
            r_done_pulse <= (w_next == ST_DONE) && (r_state != ST_DONE);
         end
      end

      assign active[gi]     = r_active;
      assign paused[gi]     = r_paused;
      assign done[gi]       = r_done;
      assign done_pulse[gi] = r_done_pulse;
   end

endmodule
`default_nettype wire

// File: tb/tb_timer_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_run_ctrl
//  Purpose  : Scoreboard bench for timer_run_ctrl (main 2-channel instance
//             plus a 1-channel AUTO_RESTART instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_timer_run_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] resetter;
   logic [1:0] ssn;
   logic [1:0] stop;
   logic [1:0] active, paused, done, done_pulse;

   logic [0:0] ar_clr, ar_ssn, ar_stop;
   logic [0:0] ar_active, ar_paused, ar_done, ar_pulse;

   timer_run_ctrl #(.NUM_CH(2), .DEBOUNCE_CYCLES(3), .AUTO_RESTART(0)) u_dut (
      .clk(clk), .rst(rst), .resetter(resetter), .start_stop_n(ssn),
      .stop_condition(stop), .active(active), .paused(paused),
      .done(done), .done_pulse(done_pulse)
   );

   timer_run_ctrl #(.NUM_CH(1), .DEBOUNCE_CYCLES(3), .AUTO_RESTART(1)) u_dut_ar (
      .clk(clk), .rst(rst), .resetter(ar_clr), .start_stop_n(ar_ssn),
      .stop_condition(ar_stop), .active(ar_active), .paused(ar_paused),
      .done(ar_done), .done_pulse(ar_pulse)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;   // -1: cycle not checked
      logic [11:0] v;
   } exp_t;
   exp_t q[$];

   int nvec  = 0;
   int fails = 0;

   // expected output model
   logic [1:0] e_act = '0, e_pau = '0, e_done = '0, e_pls = '0;
   logic       a_act = 1'b0, a_pau = 1'b0, a_done = 1'b0, a_pls = 1'b0;

   function automatic logic [11:0] model_vec();
      return {a_act, a_pau, a_done, a_pls, e_act, e_pau, e_done, e_pls};
   endfunction

   task automatic push(input int c);
      exp_t e;
      e.cyc = c;
      e.v   = model_vec();
      q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // hold a button low for n cycles, then release; rel = cycle of the release drive
   task automatic press(input bit ar, input int ch, input int n, output int rel);
      if (ar) ar_ssn = 1'b0; else ssn[ch] = 1'b0;
      tick(n);
      if (ar) ar_ssn = 1'b1; else ssn[ch] = 1'b1;
      rel = cyc;
   endtask

   // Monitor: each change of the outputs consumes one expected entry
   initial begin
      logic [11:0] cur, prev;
      bit          first;
      exp_t        e;
      first = 1'b1;
      prev  = '0;
      forever begin
         @(negedge clk);
         cur = {ar_active, ar_paused, ar_done, ar_pulse, active, paused, done, done_pulse};
         if (first || cur !== prev) begin
            nvec++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_change cyc=%0d got=%03h want=no change (prev %03h)",
                        cyc, cur, prev);
            end else begin
               e = q.pop_front();
               if (cur !== e.v || (e.cyc >= 0 && e.cyc != cyc)) begin
                  fails++;
                  $display("FAIL out_vec cyc=%0d got=%03h want=%03h at cyc=%0d",
                           cyc, cur, e.v, e.cyc);
               end
            end
         end
         prev  = cur;
         first = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      int r, e;
      rst = 1'b1; resetter = '0; ssn = 2'b00; stop = '0;
      ar_clr = '0; ar_ssn = 1'b1; ar_stop = '0;

      // reset state: all zero
      push(-1);
      tick(2);
      rst = 1'b0;
      // buttons held low across reset release for only 1 cycle: no toggle
      tick(1);
      ssn = 2'b11;
      tick(6);

      // ch0 long press -> RUN, 3 edges after the release drive
      press(0, 0, 5, r); e_act[0] = 1'b1; push(r + 3); tick(6);
      // second press -> PAUSE
      press(0, 0, 5, r); e_act[0] = 1'b0; e_pau[0] = 1'b1; push(r + 3); tick(6);
      // third press -> RUN
      press(0, 0, 5, r); e_act[0] = 1'b1; e_pau[0] = 1'b0; push(r + 3); tick(6);

      // glitch of 1 ns mid-cycle, then a 2-cycle low: no change
      #2 ssn[0] = 1'b0;
      #1 ssn[0] = 1'b1;
      tick(2);
      press(0, 0, 2, r);
      tick(8);

      // ch1 -> RUN, then terminal count
      press(0, 1, 5, r); e_act[1] = 1'b1; push(r + 3); tick(6);
      stop[1] = 1'b1; r = cyc;
      e_act[1] = 1'b0; e_done[1] = 1'b1; e_pls[1] = 1'b1; push(r + 1);
      e_pls[1] = 1'b0; push(r + 2);
      tick(1);
      stop[1] = 1'b0;
      tick(4);
      // acknowledge press -> IDLE
      press(0, 1, 4, r); e_done[1] = 1'b0; push(r + 3); tick(6);

      // auto-restart instance: RUN, DONE+pulse, then RUN the following cycle
      press(1, 0, 5, r); a_act = 1'b1; push(r + 3); tick(6);
      ar_stop = 1'b1; r = cyc;
      a_act = 1'b0; a_done = 1'b1; a_pls = 1'b1; push(r + 1);
      a_act = 1'b1; a_done = 1'b0; a_pls = 1'b0; push(r + 2);
      tick(1);
      ar_stop = 1'b0;
      tick(4);

      // ch1 -> RUN -> PAUSE, it then stays put through the ch0 priority tests
      press(0, 1, 5, r); e_act[1] = 1'b1; push(r + 3); tick(6);
      press(0, 1, 5, r); e_act[1] = 1'b0; e_pau[1] = 1'b1; push(r + 3); tick(6);

      // ch0 in RUN: toggle and stop in the same cycle -> DONE, not PAUSE
      press(0, 0, 5, r);
      tick(2);
      stop[0] = 1'b1;
      e_act[0] = 1'b0; e_done[0] = 1'b1; e_pls[0] = 1'b1; push(r + 3);
      e_pls[0] = 1'b0; push(r + 4);
      tick(1);
      stop[0] = 1'b0;
      tick(4);
      press(0, 0, 3, r); e_done[0] = 1'b0; push(r + 3); tick(6);
      press(0, 0, 3, r); e_act[0] = 1'b1; push(r + 3); tick(6);
      // resetter together with toggle -> IDLE (toggle alone would give PAUSE)
      press(0, 0, 5, r);
      tick(2);
      resetter[0] = 1'b1;
      e_act[0] = 1'b0; push(r + 3);
      tick(1);
      resetter[0] = 1'b0;
      tick(4);
      press(0, 0, 5, r); e_act[0] = 1'b1; push(r + 3); tick(6);

      // ch0 RUN, ch1 PAUSE, ar RUN; ch0 held low, async rst between edges
      ssn[0] = 1'b0;
      tick(2);
      #3;
      e_act = '0; e_pau = '0; e_done = '0; e_pls = '0; a_act = 1'b0;
      push(cyc);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      ssn[0] = 1'b1;
      tick(6);
      // fresh minimum-length press on ch0, then ch1
      press(0, 0, 3, r); e_act[0] = 1'b1; push(r + 3); tick(6);
      press(0, 1, 5, r); e_act[1] = 1'b1; push(r + 3); tick(10);

      nvec++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL pending_expect got=%0d left want=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, fails);
      $finish;
   end

endmodule
`default_nettype wire
